prim_bus_arbiter: RTL and testbench
===================================

// Module: prim_bus_arbiter
// PURPOSE
//  Two-master, one-slave arbiter in front of the shared 16-bit memory bus.
//  M0 is the Prim CPU; M1 is a secondary master (DMA / debug loader).
//  Round-robin grant is held for exactly one transfer. A timeout watchdog
//  completes transfers the slave never acknowledges, so the CPU cannot hang.
// PARAMETERS
//  TMO_W   4    width of the timeout counter
//  TMO     15   cycles with grant and no i_ack before a forced error-ack; 1..2^TMO_W-1
// PORTS
//  i_clk       in   1   clock; all state changes on posedge
//  i_reset     in   1   synchronous, active-high reset
//  i_m0_addr   in   16  M0 address
//  i_m0_dat    in   16  M0 write data
//  i_m0_bs     in   2   M0 byte select; nonzero = request
//  i_m0_we     in   1   M0 write enable
//  o_m0_dat    out  16  M0 read data
//  o_m0_ack    out  1   M0 transfer complete
//  o_m0_err    out  1   M0 transfer ended by timeout (valid with o_m0_ack)
//  i_m1_*/o_m1_*        identical set for M1
//  o_addr      out  16  slave address
//  o_dat       out  16  slave write data
//  o_bs        out  2   slave byte select; 00 = idle
//  o_we        out  1   slave write enable
//  i_dat       in   16  slave read data
//  i_ack       in   1   slave acknowledge
// BEHAVIOUR
//  - req0 = |i_m0_bs, req1 = |i_m1_bs. Requests are levels; a master holds
//    its request until it sees its ack.
//  - Registered state: IDLE, GNT0, GNT1. Other state: r_last (last master
//    served) and the timeout counter r_tmo.
//  - IDLE: if only one master requests, go to its GNT. If both request, grant
//    ~r_last. If neither, stay in IDLE.
//  - GNTn: o_addr/o_dat/o_bs/o_we = master n inputs (combinational mux).
//    o_mn_dat = i_dat. o_mn_ack = i_ack. The other master sees ack=0 and
//    dat=0.
//  - GNTn + i_ack: the ack passes through in the same cycle. Next state is
//    IDLE and r_last <= n. There is always one IDLE cycle between transfers.
//  - Minimum latency: request in cycle k -> bus driven in k+1 -> ack at the
//    earliest in k+1. A master that keeps requesting can be re-granted no
//    sooner than k+3.
//  - GNTn: if master n drops its request before ack (protocol violation), go
//    to IDLE. No ack is issued and r_last is unchanged.
//  - Timeout:
//    - r_tmo clears on entry to GNTn and increments each GNT cycle without
//      i_ack.
//    - When r_tmo == TMO and there is still no i_ack: o_mn_ack=1, o_mn_err=1,
//      o_mn_dat=0, o_bs=00 that cycle. Next state is IDLE and r_last <= n.
//    - If i_ack arrives in the same cycle, it wins: normal ack, err=0.
//  - IDLE: o_bs=00, o_we=0, o_addr=0, o_dat=0, all master acks/errs=0.
//    A stray i_ack in IDLE is ignored.
//  - Reset: state IDLE, r_last=1 (M0 wins the first tie), r_tmo=0. All
//    outputs are 0 in the reset cycle, regardless of state.
//  - Reset mid-transfer: the grant is dropped immediately and no ack is issued.
//  - o_mn_err is only ever 1 together with o_mn_ack.
//  - No outputs are registered except via state. Paths i_ack->o_mn_ack and
//    i_m*->o_* are combinational.
// TESTING
//  1. Only M0 requests a read of 0x0010 and the slave acks in the next cycle
//     with 0x1234 -> o_m0_ack=1, o_m0_dat=0x1234, o_m1_ack=0, then IDLE for 1 cycle.
//  2. Both request continuously after reset, slave acks immediately -> grants
//     go M0,M1,M0,M1. No master is granted twice in a row.
//  3. M1 writes 0xBEEF to 0x2000 with bs=11 -> o_addr=0x2000, o_dat=0xBEEF,
//     o_we=1, o_bs=11 only during GNT1. M0 sees no ack.
//  4. Slave never acks, TMO=15 -> ack+err on the 16th GNT cycle, o_bs=00 that
//     cycle, then the bus returns to IDLE. An ack landing on cycle 16 -> err=0.
//  5. i_reset asserted in the middle of GNT0 -> o_bs=00 in that cycle, no
//     o_m0_ack. After release, a pending tie is granted to M0.
//  6. A stray i_ack in IDLE, and M0 dropping its request mid-GNT0 -> no acks
//     issued, state IDLE, r_last unchanged.

Source files
------------

// File: rtl/prim_bus_if.sv
// Bus bundle shared by the two Prim masters and the memory port.
// The arbiter takes the slave modport from each master and drives memory through the master modport.
interface prim_bus_if;
    logic [15:0] addr;
    logic [15:0] wdat;
    logic [1:0]  bs;
    logic        we;
    logic [15:0] rdat;
    logic        ack;
    logic        err;

    // Arbiter acting as target for one master (reports timeout errors back).
    modport slave (
        input  addr, wdat, bs, we,
        output rdat, ack, err
    );

    // Arbiter acting as initiator toward memory (memory never reports errors).
    modport master (
        output addr, wdat, bs, we,
        input  rdat, ack
    );
endinterface

// File: rtl/prim_bus_arbiter.sv
// Two-master round-robin arbiter for the shared 16-bit memory bus.
// Grant lasts exactly one transfer; a watchdog error-acks transfers the slave never finishes.
module prim_bus_arbiter #(
    parameter int TMO_W = 4,
    parameter int TMO   = 15
) (
    input  logic         i_clk,
    input  logic         i_reset,
    prim_bus_if.slave    m0,
    prim_bus_if.slave    m1,
    prim_bus_if.master   mem
);
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

    localparam logic [TMO_W-1:0] TMO_V = TMO_W'(TMO);

    state_t           state_reg, state_next;
    logic             r_last;
    logic [TMO_W-1:0] r_tmo;

    logic req0, req1;
    logic granted, gnt_sel, sel_req;
    logic done_ok, done_tmo;

    assign req0     = |m0.bs;
    assign req1     = |m1.bs;
    assign granted  = (state_reg == GNT0) || (state_reg == GNT1);
    assign gnt_sel  = (state_reg == GNT1);
    assign sel_req  = gnt_sel ? req1 : req0;
    // A master that abandons its request gets neither a normal nor a timeout ack.
    assign done_ok  = granted && sel_req && mem.ack;
    assign done_tmo = granted && sel_req && !mem.ack && (r_tmo == TMO_V);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= IDLE;
            r_last    <= 1'b1;
            r_tmo     <= '0;
        end else begin
            state_reg <= state_next;
            // Held at zero while idle so every grant starts counting from 0.
            if (!granted)
                r_tmo <= '0;
            else if (!mem.ack)
                r_tmo <= r_tmo + 1'b1;
            if (done_ok || done_tmo)
                r_last <= gnt_sel;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req0 && (!req1 || r_last))
                    state_next = GNT0;
                else if (req1)
                    state_next = GNT1;
                else
                    state_next = IDLE;
            end
            GNT0, GNT1: begin
                if (!sel_req || done_ok || done_tmo)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem.addr = '0;
        mem.wdat = '0;
        mem.bs   = '0;
        mem.we   = 1'b0;
        m0.rdat  = '0;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m1.rdat  = '0;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        if (granted && !i_reset) begin
            mem.addr = gnt_sel ? m1.addr : m0.addr;
            mem.wdat = gnt_sel ? m1.wdat : m0.wdat;
            mem.we   = gnt_sel ? m1.we   : m0.we;
            // Byte select is withdrawn in the forced-completion cycle.
            mem.bs   = done_tmo ? 2'b00 : (gnt_sel ? m1.bs : m0.bs);
            if (gnt_sel) begin
                m1.rdat = done_tmo ? 16'h0000 : mem.rdat;
                m1.ack  = done_ok || done_tmo;
                m1.err  = done_tmo;
            end else begin
                m0.rdat = done_tmo ? 16'h0000 : mem.rdat;
                m0.ack  = done_ok || done_tmo;
                m0.err  = done_tmo;
            end
        end
    end
endmodule

// File: tb/tb_prim_bus_arbiter.sv
// Directed vector bench for prim_bus_arbiter: one table row per clock cycle,
// plus hand-written watchdog sequences for both masters.
module tb_prim_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    prim_bus_if m0_bus ();
    prim_bus_if m1_bus ();
    prim_bus_if mem_bus ();

    prim_bus_arbiter #(.TMO_W(4), .TMO(15)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .mem     (mem_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  bs0;
        logic [1:0]  bs1;
        logic        ack;
        logic [15:0] rdat;
        logic [1:0]  e_bs;
        logic        e_we;
        logic [15:0] e_addr;
        logic [15:0] e_wdat;
        logic        e_ack0;
        logic        e_err0;
        logic [15:0] e_dat0;
        logic        e_ack1;
        logic        e_err1;
        logic [15:0] e_dat1;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    // Expected outputs when no grant is active (idle or reset).
    function automatic vec_t vz(logic r, logic [1:0] b0, logic [1:0] b1, logic a, logic [15:0] d);
        vec_t v;
        v = '{r, b0, b1, a, d, 2'b00, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0};
        return v;
    endfunction

    // Expected outputs while M0 (addr 0x0010, wdat 0x1111, read) holds the bus.
    function automatic vec_t vg0(logic [1:0] b0, logic [1:0] b1, logic a, logic [15:0] d, logic eack);
        vec_t v;
        v = '{1'b0, b0, b1, a, d, b0, 1'b0, 16'h0010, 16'h1111, eack, 1'b0, d, 1'b0, 1'b0, 16'h0};
        return v;
    endfunction

    // Expected outputs while M1 (addr 0x2000, wdat 0xBEEF, write) holds the bus.
    function automatic vec_t vg1(logic [1:0] b0, logic [1:0] b1, logic a, logic [15:0] d, logic eack);
        vec_t v;
        v = '{1'b0, b0, b1, a, d, b1, 1'b1, 16'h2000, 16'hBEEF, 1'b0, 1'b0, 16'h0, eack, 1'b0, d};
        return v;
    endfunction

    task automatic chk(string nm, int row, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, compare before the rising edge.
    task automatic run_row(vec_t v, int row);
        @(negedge clk);
        rst            = v.rst;
        m0_bus.bs      = v.bs0;
        m1_bus.bs      = v.bs1;
        mem_bus.ack    = v.ack;
        mem_bus.rdat   = v.rdat;
        #1;
        chk("o_bs",     row, {14'h0, mem_bus.bs},   {14'h0, v.e_bs});
        chk("o_we",     row, {15'h0, mem_bus.we},   {15'h0, v.e_we});
        chk("o_addr",   row, mem_bus.addr,          v.e_addr);
        chk("o_dat",    row, mem_bus.wdat,          v.e_wdat);
        chk("o_m0_ack", row, {15'h0, m0_bus.ack},   {15'h0, v.e_ack0});
        chk("o_m0_err", row, {15'h0, m0_bus.err},   {15'h0, v.e_err0});
        chk("o_m0_dat", row, m0_bus.rdat,           v.e_dat0);
        chk("o_m1_ack", row, {15'h0, m1_bus.ack},   {15'h0, v.e_ack1});
        chk("o_m1_err", row, {15'h0, m1_bus.err},   {15'h0, v.e_err1});
        chk("o_m1_dat", row, m1_bus.rdat,           v.e_dat1);
        $display("row %0d rst=%b bs0=%b bs1=%b ack=%b -> o_bs=%b m0_ack=%b m0_err=%b m1_ack=%b m1_err=%b",
                 row, v.rst, v.bs0, v.bs1, v.ack, mem_bus.bs, m0_bus.ack, m0_bus.err, m1_bus.ack, m1_bus.err);
    endtask

    initial begin
        vec_t v;
        m0_bus.addr = 16'h0010; m0_bus.wdat = 16'h1111; m0_bus.we = 1'b0; m0_bus.bs = 2'b00;
        m1_bus.addr = 16'h2000; m1_bus.wdat = 16'hBEEF; m1_bus.we = 1'b1; m1_bus.bs = 2'b00;
        mem_bus.ack = 1'b0; mem_bus.rdat = 16'h0;

        // Reset cycle with everything active: all outputs must be 0.
        vecs.push_back(vz(1, 2'b11, 2'b11, 1, 16'h1234));
        // Stray ack in IDLE is ignored.
        vecs.push_back(vz(0, 2'b00, 2'b00, 1, 16'h1234));
        // M0 reads 0x0010; slave answers 0x1234 one cycle later.
        vecs.push_back(vz(0, 2'b01, 2'b00, 0, 16'h0));
        vecs.push_back(vg0(2'b01, 2'b00, 1, 16'h1234, 1));
        vecs.push_back(vz(0, 2'b00, 2'b00, 0, 16'h0));
        // M1 writes 0xBEEF to 0x2000, one wait state.
        vecs.push_back(vz(0, 2'b00, 2'b11, 0, 16'h0));
        vecs.push_back(vg1(2'b00, 2'b11, 0, 16'h5555, 0));
        vecs.push_back(vg1(2'b00, 2'b11, 1, 16'h0000, 1));
        // Both request continuously, slave acks at once: M0, M1, M0.
        vecs.push_back(vz(0, 2'b11, 2'b11, 1, 16'hA5A5));
        vecs.push_back(vg0(2'b11, 2'b11, 1, 16'hA5A5, 1));
        vecs.push_back(vz(0, 2'b11, 2'b11, 1, 16'hA5A5));
        vecs.push_back(vg1(2'b11, 2'b11, 1, 16'hA5A5, 1));
        vecs.push_back(vz(0, 2'b11, 2'b11, 1, 16'hA5A5));
        vecs.push_back(vg0(2'b11, 2'b11, 1, 16'hA5A5, 1));
        // M0 drops its request mid-grant while the slave acks: no ack; last served stays M0.
        vecs.push_back(vz(0, 2'b11, 2'b00, 0, 16'h0));
        vecs.push_back(vg0(2'b11, 2'b00, 0, 16'h3333, 0));
        vecs.push_back(vg0(2'b00, 2'b00, 1, 16'h0000, 0));
        // Tie now goes to M1.
        vecs.push_back(vz(0, 2'b01, 2'b01, 0, 16'h0));
        vecs.push_back(vg1(2'b01, 2'b01, 1, 16'h7777, 1));
        vecs.push_back(vz(0, 2'b00, 2'b00, 0, 16'h0));
        // M0 served (last=M0), re-granted at k+3, then reset mid-grant.
        vecs.push_back(vz(0, 2'b11, 2'b00, 0, 16'h0));
        vecs.push_back(vg0(2'b11, 2'b00, 1, 16'h4444, 1));
        vecs.push_back(vz(0, 2'b11, 2'b00, 0, 16'h0));
        vecs.push_back(vg0(2'b11, 2'b11, 0, 16'h0, 0));
        vecs.push_back(vz(1, 2'b11, 2'b11, 1, 16'h9999));
        // After reset the tie goes to M0 again.
        vecs.push_back(vz(0, 2'b11, 2'b11, 0, 16'h0));
        vecs.push_back(vg0(2'b11, 2'b11, 1, 16'h0F0F, 1));
        vecs.push_back(vz(0, 2'b00, 2'b00, 0, 16'h0));

        for (int i = 0; i < vecs.size(); i++)
            run_row(vecs[i], i);

        // Watchdog on M0: 15 silent grant cycles, forced error-ack on the 16th.
        run_row(vz(0, 2'b11, 2'b00, 0, 16'h0), 100);
        for (int c = 1; c <= 15; c++)
            run_row(vg0(2'b11, 2'b00, 0, 16'hFFFF, 0), 100 + c);
        v = vg0(2'b11, 2'b00, 0, 16'hFFFF, 1);
        v.e_bs = 2'b00; v.e_err0 = 1'b1; v.e_dat0 = 16'h0;
        run_row(v, 116);
        run_row(vz(0, 2'b00, 2'b00, 0, 16'h0), 117);

        // Watchdog on M1: a real ack landing on the 16th cycle wins, no error.
        run_row(vz(0, 2'b00, 2'b11, 0, 16'h0), 200);
        for (int c = 1; c <= 15; c++)
            run_row(vg1(2'b00, 2'b11, 0, 16'h1111, 0), 200 + c);
        run_row(vg1(2'b00, 2'b11, 1, 16'hCAFE, 1), 216);
        run_row(vz(0, 2'b00, 2'b00, 0, 16'h0), 217);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
